// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latched 32-bit display word driving a 4-digit common-anode
// seven-segment display, either as scanned hex digits or as raw an/seg bits.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   wr_en    one-cycle write strobe for the display word
//   wr_data  word latched when wr_en=1
//   rd_data  currently latched word
//   an       digit anodes, active-low, an[0] = rightmost digit
//   seg      cathodes, active-low, {dp,g,f,e,d,c,b,a}
//
// Word layout: [31] raw mode, [24] leading-zero blank, [23:20] digit enables,
// [19:16] dp enables, [15:0] four hex nibbles. Raw mode: an=W[11:8], seg=W[7:0].

// Per-digit segment pattern and blanking decision.
module seg7_digit (
  input  logic [3:0] nibble,
  input  logic       dp_en,
  input  logic       dig_en,
  input  logic       lz_blank,
  output logic       dark,
  output logic [7:0] seg
);
  logic [7:0] code;

  always_comb begin
    unique case (nibble)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
  end

  assign dark = !dig_en || lz_blank;
  assign seg  = {~dp_en, code[6:0]};
endmodule

module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_BIT  = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  localparam logic [DIV_BIT-1:0] CNT_LAST = DIV_BIT'(SCAN_DIV - 1);

  logic [31:0]        w;
  logic [DIV_BIT-1:0] cnt;
  logic [1:0]         idx;
  logic [3:0]         dark;
  logic [3:0]         lz;
  logic [3:0][7:0]    dseg;
  logic [3:0]         an_nxt;
  logic [7:0]         seg_nxt;

  assign rd_data = w;

  // Digit i is leading-zero blanked when nibbles i..3 are all zero; digit 0
  // always shows so a zero value reads "0" rather than an empty display.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    if (gi == 0) begin : g_lsd
      assign lz[gi] = 1'b0;
    end else begin : g_upper
      assign lz[gi] = w[24] && (w[15:4*gi] == '0);
    end

    seg7_digit u_dig (
      .nibble  (w[4*gi +: 4]),
      .dp_en   (w[16+gi]),
      .dig_en  (w[20+gi]),
      .lz_blank(lz[gi]),
      .dark    (dark[gi]),
      .seg     (dseg[gi])
    );
  end

  // Outputs are registered from the current W/idx, so a write or idx step
  // shows up one edge later and an/seg never glitch between edges.
  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 8'hFF;
    if (w[31]) begin
      an_nxt  = w[11:8];
      seg_nxt = w[7:0];
    end else if (!dark[idx]) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = dseg[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w   <= '0;
      cnt <= '0;
      idx <= '0;
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      if (wr_en) w <= wr_data;
      // Prescaler runs in both modes so the scan position survives mode switches.
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [3:0]  an;
  logic [7:0]  seg;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(.SCAN_DIV(4), .DIV_BIT(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [31:0]     data;
    logic [3:0][3:0] an;   // expected an per idx
    logic [3:0][7:0] seg;  // expected seg per idx
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"count",   32'h00F0_1234, {4'h7,4'hB,4'hD,4'hE}, {8'hF9,8'hA4,8'hB0,8'h99}};
    vecs[1] = '{"lzb_dp7", 32'h01F5_0007, {4'hF,4'hF,4'hF,4'hE}, {8'hFF,8'hFF,8'hFF,8'h78}};
    vecs[2] = '{"lzb_zero",32'h01F0_0000, {4'hF,4'hF,4'hF,4'hE}, {8'hFF,8'hFF,8'hFF,8'hC0}};
    vecs[3] = '{"mask",    32'h0050_ABCD, {4'hF,4'hB,4'hF,4'hE}, {8'hFF,8'h83,8'hFF,8'hA1}};
    vecs[4] = '{"lzb_mid", 32'h01F0_0305, {4'hF,4'hB,4'hD,4'hE}, {8'hFF,8'hB0,8'hC0,8'h92}};
    vecs[5] = '{"raw",     32'h8000_0B92, {4'hB,4'hB,4'hB,4'hB}, {8'h92,8'h92,8'h92,8'h92}};
    vecs[6] = '{"dp_all",  32'h00FF_EF00, {4'h7,4'hB,4'hD,4'hE}, {8'h06,8'h0E,8'h40,8'h40}};

    // Reset state held for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_an",  {28'h0, an},  32'hF);
      chk("rst_seg", {24'h0, seg}, 32'hFF);
      chk("rst_rd",  rd_data,      32'h0);
    end

    // Table: reset, write on the first free cycle, then walk a full scan
    // plus one. After the j-th tick following the write, idx = (j/4)%4.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      write(vecs[v].data);
      chk({vecs[v].name, "_rd"}, rd_data, vecs[v].data);
      for (int j = 1; j <= 16; j++) begin
        tick();
        chk({vecs[v].name, "_an"},  {28'h0, an},  {28'h0, vecs[v].an[(j/4)%4]});
        chk({vecs[v].name, "_seg"}, {24'h0, seg}, {24'h0, vecs[v].seg[(j/4)%4]});
      end
    end

    // Raw -> hex resumes at the current scan position.
    do_reset();
    write(32'h8000_0B92);          // e1
    for (int i = 0; i < 5; i++) tick(); // e2..e6, idx=1 cnt=2
    write(32'h00F0_1234);          // e7
    chk("sw_raw_an",  {28'h0, an},  32'hB);
    chk("sw_raw_seg", {24'h0, seg}, 32'h92);
    tick();
    chk("sw_hex1_an",  {28'h0, an},  32'hD);
    chk("sw_hex1_seg", {24'h0, seg}, 32'hB0);
    tick();
    chk("sw_hex2_an",  {28'h0, an},  32'hB);
    chk("sw_hex2_seg", {24'h0, seg}, 32'hA4);

    // Write coinciding with prescaler terminal count: new W on new idx.
    do_reset();
    write(32'h00F0_1234);          // e1
    tick();
    tick();                        // e3, cnt=3
    write(32'h00F0_5678);          // e4
    chk("tc_rd",      rd_data,     32'h00F0_5678);
    chk("tc_old_an",  {28'h0, an}, 32'hE);
    chk("tc_old_seg", {24'h0, seg},32'h99);
    tick();
    chk("tc_new_an",  {28'h0, an}, 32'hD);
    chk("tc_new_seg", {24'h0, seg},32'hF8);

    // Reset with simultaneous write mid-scan.
    do_reset();
    write(32'h00F0_1234);
    for (int i = 0; i < 6; i++) tick();
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'hFFFF_FFFF;
    tick();
    chk("rw_rd",  rd_data,      32'h0);
    chk("rw_an",  {28'h0, an},  32'hF);
    chk("rw_seg", {24'h0, seg}, 32'hFF);
    reset = 1'b0;
    write(32'h00F0_1234);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("rw_scan_an", {28'h0, an}, (j < 4) ? 32'hE : 32'hD);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
